// File: rtl/ll_stream_decimator.sv
// Raster-order token decimator: keeps one pixel per DECIM x DECIM block and buffers kept
// tokens in a DEPTH-entry FIFO. Define LL_STREAM_LAST_EN to add the Out1_LAST end-of-frame flag.
`timescale 1ns/1ps
module ll_stream_decimator #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int IMG_W  = 512,
   parameter int IMG_H  = 512,
   parameter int DECIM  = 2
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic [DATA_W-1:0]            In1_DATA,
   input  logic [15:0]                  In1_COUNT,
   input  logic                         In1_SEND,
   output logic                         In1_ACK,
   input  logic                         Out1_RDY,
   input  logic                         Out1_ACK,
   output logic [DATA_W-1:0]            Out1_DATA,
   output logic [15:0]                  Out1_COUNT,
   output logic                         Out1_SEND,
`ifdef LL_STREAM_LAST_EN
   output logic                         Out1_LAST,
`endif
   output logic [$clog2(DEPTH+1)-1:0]   Level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
`ifdef LL_STREAM_LAST_EN
   localparam int EW = DATA_W + 1;
`else
   localparam int EW = DATA_W;
`endif

   localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
   localparam logic [PW-1:0] PH_MAX   = PW'(DECIM - 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [PW-1:0] cphase_q, cphase_d, rphase_q, rphase_d;
   logic          full, empty, keep, push, pop;
   logic [EW-1:0] entry;
   logic          unused_inputs;

   // COUNT from upstream and ACK from downstream carry no information this actor needs.
   assign unused_inputs = ^{In1_COUNT, Out1_ACK};

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);
   assign keep  = (cphase_q == '0) && (rphase_q == '0);

   // Handshake: a token moves on In1 whenever In1_ACK is high and on Out1 whenever
   // Out1_SEND is high; no bypass, so a full FIFO refuses input even while popping.
   assign In1_ACK    = RESET & In1_SEND & ~full;
   assign Out1_SEND  = RESET & Out1_RDY & ~empty;
   assign Out1_COUNT = {15'd0, Out1_SEND};
   assign Out1_DATA  = mem_q[rd_ptr_q][DATA_W-1:0];
   assign Level      = level_q;
   assign push       = In1_ACK & keep;
   assign pop        = Out1_SEND;

`ifdef LL_STREAM_LAST_EN
   localparam logic [CW-1:0] LAST_COL = CW'(((IMG_W - 1) / DECIM) * DECIM);
   localparam logic [RW-1:0] LAST_ROW = RW'(((IMG_H - 1) / DECIM) * DECIM);
   assign entry     = {(col_q == LAST_COL) && (row_q == LAST_ROW), In1_DATA};
   assign Out1_LAST = Out1_SEND & mem_q[rd_ptr_q][DATA_W];
`else
   assign entry = In1_DATA;
`endif

   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      cphase_d = cphase_q;
      rphase_d = rphase_q;
      if (In1_ACK) begin
         if (col_q == COL_MAX) begin
            col_d    = '0;
            cphase_d = '0;
            if (row_q == ROW_MAX) begin
               row_d    = '0;
               rphase_d = '0;
            end else begin
               row_d    = row_q + RW'(1);
               rphase_d = (rphase_q == PH_MAX) ? '0 : rphase_q + PW'(1);
            end
         end else begin
            col_d    = col_q + CW'(1);
            cphase_d = (cphase_q == PH_MAX) ? '0 : cphase_q + PW'(1);
         end
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         col_q    <= '0;
         row_q    <= '0;
         cphase_q <= '0;
         rphase_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         col_q    <= col_d;
         row_q    <= row_d;
         cphase_q <= cphase_d;
         rphase_q <= rphase_d;
         if (push) mem_q[wr_ptr_q] <= entry;
      end
   end

endmodule
